// File: rtl/syn_md_pkg.sv
// rtl/syn_md_pkg.sv - shared state encoding and safe switch levels for the sync-mode sequencer
package syn_md_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_S2_OFF,
        ST_W1,
        ST_RT_ON,
        ST_W2,
        ST_S1_ON,
        ST_W3,
        ST_SOFT_EN,
        ST_ACTIVE,
        ST_SOFT_DIS,
        ST_W4,
        ST_S1_OFF,
        ST_W5,
        ST_RT_OFF,
        ST_W6,
        ST_S2_ON
    } state_t;

    localparam logic SAFE_SOFT_D = 1'b1;
    localparam logic SAFE_RT_SW  = 1'b0;
    localparam logic SAFE_SW1    = 1'b0;
    localparam logic SAFE_SW2    = 1'b1;

endpackage

// File: rtl/syn_md_wait_cnt.sv
// rtl/syn_md_wait_cnt.sv - loadable down-counter shared by dead-time and hold-time waits
module syn_md_wait_cnt #(
    parameter int CW = 16
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] value,
    output logic          expired
);

    // load takes priority; otherwise count down and rest at zero
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - CW'(1);
        end
    end

    assign expired = (value == '0);

endmodule

// File: rtl/syn_md_seq.sv
// rtl/syn_md_seq.sv - break-before-make sequencer for the synchronous-mode switch set
module syn_md_seq
    import syn_md_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [CW-1:0] dead_time,
    input  logic [CW-1:0] hold_time,
    output logic          soft_d,
    output logic          rt_sw,
    output logic          sw1,
    output logic          sw2,
    output logic          busy,
    output logic          active,
    output logic          done
);

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] dead_q;
    logic [CW-1:0] hold_q;
    logic [CW-1:0] cnt_load_val;
    logic [CW-1:0] cnt_value;
    logic          cnt_load;
    logic          cnt_expired;
    logic          stop_pend;
    logic          stop_seen;

    assign stop_seen = stop | stop_pend;
    assign busy      = (state != ST_IDLE);

    syn_md_wait_cnt #(.CW(CW)) u_wait_cnt (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .value    (cnt_value),
        .expired  (cnt_expired)
    );

    // capture run timing at start and remember a stop raised before the mode is reached
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            dead_q    <= CW'(1);
            hold_q    <= '0;
            stop_pend <= 1'b0;
        end else if (state == ST_IDLE) begin
            stop_pend <= 1'b0;
            if (start) begin
                dead_q <= (dead_time == '0) ? CW'(1) : dead_time;
                hold_q <= hold_time;
            end
        end else if (stop && (state == ST_S2_OFF || state == ST_W1 || state == ST_RT_ON ||
                              state == ST_W2 || state == ST_S1_ON || state == ST_W3 ||
                              state == ST_SOFT_EN)) begin
            stop_pend <= 1'b1;
        end
    end

    // each switch step arms the shared counter for the wait that follows it
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = dead_q - CW'(1);
        case (state)
            ST_S2_OFF, ST_RT_ON, ST_S1_ON,
            ST_SOFT_DIS, ST_S1_OFF, ST_RT_OFF: cnt_load = 1'b1;
            ST_SOFT_EN: begin
                cnt_load     = 1'b1;
                cnt_load_val = hold_q - CW'(1);
            end
            default: ;
        endcase
    end

    // state register
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // sequence; an early stop diverts to the teardown step undoing the last switch changed
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (start) next_state = ST_S2_OFF;
            ST_S2_OFF:   next_state = ST_W1;
            ST_W1:       if (cnt_expired) next_state = stop_seen ? ST_S2_ON : ST_RT_ON;
            ST_RT_ON:    next_state = ST_W2;
            ST_W2:       if (cnt_expired) next_state = stop_seen ? ST_RT_OFF : ST_S1_ON;
            ST_S1_ON:    next_state = ST_W3;
            ST_W3:       if (cnt_expired) next_state = stop_seen ? ST_S1_OFF : ST_SOFT_EN;
            ST_SOFT_EN:  next_state = ST_ACTIVE;
            ST_ACTIVE:   if (stop_seen || (hold_q != '0 && cnt_value == '0)) next_state = ST_SOFT_DIS;
            ST_SOFT_DIS: next_state = ST_W4;
            ST_W4:       if (cnt_expired) next_state = ST_S1_OFF;
            ST_S1_OFF:   next_state = ST_W5;
            ST_W5:       if (cnt_expired) next_state = ST_RT_OFF;
            ST_RT_OFF:   next_state = ST_W6;
            ST_W6:       if (cnt_expired) next_state = ST_S2_ON;
            ST_S2_ON:    next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // switch registers change on the edge that enters their step, so one switch moves per edge
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            soft_d <= SAFE_SOFT_D;
            rt_sw  <= SAFE_RT_SW;
            sw1    <= SAFE_SW1;
            sw2    <= SAFE_SW2;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            done   <= 1'b0;
            active <= (next_state == ST_ACTIVE);
            case (next_state)
                ST_S2_OFF:   sw2    <= ~SAFE_SW2;
                ST_RT_ON:    rt_sw  <= ~SAFE_RT_SW;
                ST_S1_ON:    sw1    <= ~SAFE_SW1;
                ST_SOFT_EN:  soft_d <= ~SAFE_SOFT_D;
                ST_SOFT_DIS: soft_d <= SAFE_SOFT_D;
                ST_S1_OFF:   sw1    <= SAFE_SW1;
                ST_RT_OFF:   rt_sw  <= SAFE_RT_SW;
                ST_S2_ON: begin
                    sw2  <= SAFE_SW2;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
